// File: rtl/qsys_key_pio_in_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qsys_key_pio_in_pkg
// Description : Shared register addresses, edge-type encodings and the
//               edge-selection helper for the key/switch input PIO.
// Revision    : 1.0 - initial release
// ============================================================================
package qsys_key_pio_in_pkg;

  // Avalon slave register map (word addresses)
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // Which debounced transitions are recorded in EDGECAP
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // True when an accepted transition matches the configured edge type
  function automatic logic edge_match(input int edge_type, input logic rise,
                                      input logic fall);
    logic hit;
    hit = 1'b0;
    if (edge_type == EDGE_RISE)      hit = rise;
    else if (edge_type == EDGE_FALL) hit = fall;
    else if (edge_type == EDGE_ANY)  hit = rise | fall;
    return hit;
  endfunction

endpackage : qsys_key_pio_in_pkg
`default_nettype wire

// File: rtl/qsys_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module      : qsys_debounce_bit
// Description : One input bit: 2-FF synchroniser, consecutive-stable counter
//               and accepted-value FF. rise/fall pulse combinationally on the
//               clock edge at which the accepted value toggles.
// Revision    : 1.0 - initial release
// ============================================================================
module qsys_debounce_bit
  import qsys_key_pio_in_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_BIT       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_pin,
  output logic stable,
  output logic rise,
  output logic fall
);

  // Wide enough to hold DEBOUNCE_CYCLES-1; the counter never wraps
  localparam int                  c_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               r_s1;
  logic               r_s2;
  logic               r_stable;
  logic [c_CNT_W-1:0] r_cnt;
  logic               w_mismatch;
  logic               w_accept;

  assign w_mismatch = (r_s2 != r_stable);
  assign w_accept   = w_mismatch && !(r_cnt < c_LAST);

  // Two-stage synchroniser for the asynchronous board pin
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= RESET_BIT;
      r_s2 <= RESET_BIT;
    end else begin
      r_s1 <= in_pin;
      r_s2 <= r_s1;
    end
  end

  // Count consecutive mismatching clocks; accept on the last one
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_stable <= RESET_BIT;
    end else if (!w_mismatch) begin
      r_cnt    <= '0;
    end else if (!w_accept) begin
      r_cnt    <= r_cnt + c_CNT_W'(1);
    end else begin
      r_cnt    <= '0;
      r_stable <= r_s2;
    end
  end

  assign stable = r_stable;
  assign rise   = w_accept &  r_s2;
  assign fall   = w_accept & ~r_s2;

endmodule : qsys_debounce_bit
`default_nettype wire

// File: rtl/qsys_key_pio_in.sv
`default_nettype none
// ============================================================================
// Module      : qsys_key_pio_in
// Description : Avalon-MM input PIO for push-buttons/switches. Debounced
//               DATA, IRQMASK, write-1-to-clear EDGECAP and a level IRQ.
// Revision    : 1.0 - initial release
// ============================================================================
module qsys_key_pio_in
  import qsys_key_pio_in_pkg::*;
#(
  parameter int               WIDTH           = 3,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_capture;
  logic [WIDTH-1:0] w_clear;
  logic             w_write;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;
  logic             w_unused_wdata;

  // One independent debouncer per input bit
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      qsys_debounce_bit #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_BIT       (RESET_VALUE[i])
      ) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .in_pin (in_port[i]),
        .stable (w_stable[i]),
        .rise   (w_rise[i]),
        .fall   (w_fall[i])
      );
      assign w_capture[i] = edge_match(EDGE_TYPE, w_rise[i], w_fall[i]);
    end
  endgenerate

  assign w_write = chipselect && !write_n;
  assign w_clear = (w_write && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0]
                                                          : '0;
  // Upper write-data bits are don't-care
  assign w_unused_wdata = ^{1'b0, writedata};

  // Mask register and edge capture; a new edge wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irqmask <= '0;
      r_edgecap <= '0;
    end else begin
      if (w_write && (address == ADDR_IRQMASK))
        r_irqmask <= writedata[WIDTH-1:0];
      r_edgecap <= (r_edgecap & ~w_clear) | w_capture;
    end
  end

  // Zero-latency read mux, upper bits zero
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = w_stable;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = r_irqmask;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = r_edgecap;
      default:      readdata = '0;
    endcase
  end

  assign irq = |(r_edgecap & r_irqmask);

endmodule : qsys_key_pio_in
`default_nettype wire

// File: tb/tb_qsys_key_pio_in.sv
`default_nettype none
// ============================================================================
// Module      : tb_qsys_key_pio_in
// Description : Self-checking bench for qsys_key_pio_in. Two instances
//               (falling-edge and any-edge capture) share stimulus and are
//               compared against a window-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qsys_key_pio_in;

  localparam int D = 4;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [2:0]  in_port;
  logic [31:0] readdata_f, readdata_a;
  logic        irq_f, irq_a;

  int n_total = 0;
  int n_bad   = 0;

  qsys_key_pio_in #(.WIDTH(3), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1),
                    .RESET_VALUE(3'b111)) u_dut_fall (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata_f),
    .in_port(in_port), .irq(irq_f));

  qsys_key_pio_in #(.WIDTH(3), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2),
                    .RESET_VALUE(3'b111)) u_dut_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata_a),
    .in_port(in_port), .irq(irq_a));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: a change is accepted once the last D synchronised
  // samples since reset all disagree with the accepted value.
  logic [2:0] m_pin_d1, m_pin_d2;
  logic [2:0] m_stable, m_mask, m_cap_f, m_cap_a;
  logic [2:0] m_win[$];

  always @(posedge clk) begin
    logic all_diff;
    logic new_val;
    if (reset) begin
      m_pin_d1 = 3'b111;
      m_pin_d2 = 3'b111;
      m_stable = 3'b111;
      m_mask   = 3'b000;
      m_cap_f  = 3'b000;
      m_cap_a  = 3'b000;
      m_win.delete();
    end else begin
      m_win.push_back(m_pin_d2);
      if (m_win.size() > D) void'(m_win.pop_front());
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[2:0];
      if (chipselect && !write_n && address == 2'd3) begin
        m_cap_f = m_cap_f & ~writedata[2:0];
        m_cap_a = m_cap_a & ~writedata[2:0];
      end
      for (int i = 0; i < 3; i++) begin
        if (m_win.size() == D) begin
          all_diff = 1'b1;
          foreach (m_win[k]) if (m_win[k][i] == m_stable[i]) all_diff = 1'b0;
          if (all_diff) begin
            new_val     = ~m_stable[i];
            m_stable[i] = new_val;
            m_cap_a[i]  = 1'b1;
            if (!new_val) m_cap_f[i] = 1'b1;
          end
        end
      end
      m_pin_d2 = m_pin_d1;
      m_pin_d1 = in_port;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [1:0] a, input logic [2:0] cap);
    case (a)
      2'd0:    return {29'b0, m_stable};
      2'd2:    return {29'b0, m_mask};
      2'd3:    return {29'b0, cap};
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock and compare both DUTs against the model
  task automatic tick();
    @(posedge clk);
    #2;
    chk("model_rd_f",  readdata_f, exp_rd(address, m_cap_f));
    chk("model_rd_a",  readdata_a, exp_rd(address, m_cap_a));
    chk("model_irq_f", {31'b0, irq_f}, {31'b0, |(m_cap_f & m_mask)});
    chk("model_irq_a", {31'b0, irq_a}, {31'b0, |(m_cap_a & m_mask)});
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic rd(input string tag, input logic [1:0] a,
                    input logic [31:0] exp_f, input logic [31:0] exp_a);
    address = a;
    #1;
    chk({tag, "_f"}, readdata_f, exp_f);
    chk({tag, "_a"}, readdata_a, exp_a);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    reset = 1'b1; in_port = 3'b111; address = 2'd0;
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;

    // 1: reset state
    ticks(2);
    reset = 1'b0;
    rd("t1_data", 2'd0, 32'h7, 32'h7);
    rd("t1_mask", 2'd2, 32'h0, 32'h0);
    rd("t1_cap",  2'd3, 32'h0, 32'h0);
    chk("t1_irq", {31'b0, irq_f | irq_a}, 32'h0);

    // 2: press bit0, accepted exactly 6 clocks later
    in_port = 3'b110;
    ticks(5);
    rd("t2_data5", 2'd0, 32'h7, 32'h7);
    tick();
    rd("t2_data6", 2'd0, 32'h6, 32'h6);
    rd("t2_cap",   2'd3, 32'h1, 32'h1);
    chk("t2_irq_masked", {31'b0, irq_f}, 32'h0);
    wr(2'd2, 32'h1);
    chk("t2_irq_on", {31'b0, irq_f & irq_a}, 32'h1);

    // 3: 3-clock glitch on bit1 is rejected
    in_port = 3'b100;
    ticks(3);
    in_port = 3'b110;
    ticks(8);
    rd("t3_data", 2'd0, 32'h6, 32'h6);
    rd("t3_cap",  2'd3, 32'h1, 32'h1);

    // 4: clear coinciding with a new capture keeps the bit
    in_port = 3'b111;
    ticks(8);
    in_port = 3'b110;
    ticks(5);
    address = 2'd3; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
    rd("t4_cap_kept", 2'd3, 32'h1, 32'h1);
    wr(2'd3, 32'h1);
    rd("t4_cap_clr", 2'd3, 32'h0, 32'h0);
    chk("t4_irq_off", {31'b0, irq_f | irq_a}, 32'h0);

    // 5: edge-type selection on bit2
    in_port = 3'b010;
    ticks(8);
    rd("t5_fall", 2'd3, 32'h4, 32'h4);
    wr(2'd3, 32'h4);
    in_port = 3'b110;
    ticks(8);
    rd("t5_rise", 2'd3, 32'h0, 32'h4);
    wr(2'd3, 32'h4);

    // 6: reset mid-bounce, then normal debounce of the still-low pin
    in_port = 3'b111;
    ticks(8);
    wr(2'd3, 32'h7);
    in_port = 3'b110;
    ticks(4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd("t6_data_rst", 2'd0, 32'h7, 32'h7);
    rd("t6_cap_rst",  2'd3, 32'h0, 32'h0);
    rd("t6_mask_rst", 2'd2, 32'h0, 32'h0);
    ticks(5);
    rd("t6_data5", 2'd0, 32'h7, 32'h7);
    tick();
    rd("t6_data6", 2'd0, 32'h6, 32'h6);
    rd("t6_cap6",  2'd3, 32'h1, 32'h1);

    // Random phase: bouncing pins, random bus traffic, rare resets
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) in_port = in_port ^ 3'(1 << $urandom_range(0, 2));
      address    = 2'($urandom);
      writedata  = $urandom;
      chipselect = 1'($urandom);
      write_n    = ($urandom_range(0, 2) != 0);
      tick();
    end
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_qsys_key_pio_in
`default_nettype wire
